// File: rtl/magia_eoc_pkg.sv
// Shared types and constants for the MAGIA multi-tile end-of-computation collector.
// The optional watchdog is enabled by defining MAGIA_EOC_WATCHDOG_EN.
package magia_eoc_pkg;

    typedef enum logic [1:0] {
        EOC_IDLE,
        EOC_RUN,
        EOC_DONE,
        EOC_TIMEOUT
    } eoc_state_e;

    localparam int unsigned EOC_CODE_W   = 32;
    localparam logic [31:0] EOC_TMO_CODE = 32'hDEAD_0001;

    // Width of a tile index; a single-tile mesh still gets a 1-bit id port.
    function automatic int unsigned tile_id_w(input int unsigned n_tiles);
        return (n_tiles > 1) ? $clog2(n_tiles) : 1;
    endfunction

endpackage

// File: rtl/magia_eoc_watchdog.sv
// Cycle counter for the collector watchdog (built only with MAGIA_EOC_WATCHDOG_EN).
// Pulses expire_o in the enabled cycle whose count equals limit_i - 1; limit 0 never expires.
module magia_eoc_watchdog
    import magia_eoc_pkg::*;
#(
    parameter int unsigned TMO_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [TMO_W-1:0] limit_i,
    output logic             expire_o
);

    logic [TMO_W-1:0] count_q, count_d;

    // NOTE: combinational blocks assign a default first so no path leaves a variable unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + TMO_W'(1);
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = enable_i && (limit_i != '0) && (count_q == limit_i - TMO_W'(1));

endmodule

// File: rtl/magia_eoc_collector.sv
// Multi-tile end-of-computation collector: tracks per-tile reports, keeps the first nonzero exit code
// and raises one global EOC. Define MAGIA_EOC_WATCHDOG_EN to add the timeout watchdog.
module magia_eoc_collector
    import magia_eoc_pkg::*;
#(
    parameter  int unsigned             N_TILES  = 16,
    parameter  int unsigned             CODE_W   = EOC_CODE_W,
    parameter  int unsigned             TMO_W    = 32,
    parameter  logic [CODE_W-1:0]       TMO_CODE = CODE_W'(EOC_TMO_CODE),
    localparam int unsigned             ID_W     = tile_id_w(N_TILES)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic                        clear_i,
    input  logic [N_TILES-1:0]          tile_mask_i,
    input  logic [TMO_W-1:0]            timeout_i,
    input  logic [N_TILES-1:0]          rpt_valid_i,
    input  logic [N_TILES*CODE_W-1:0]   rpt_code_i,
    output logic [N_TILES-1:0]          rpt_ready_o,
    output logic                        busy_o,
    output logic                        eoc_o,
    output logic [CODE_W-1:0]           exit_code_o,
    output logic [ID_W-1:0]             fail_id_o,
    output logic [N_TILES-1:0]          done_map_o,
    output logic                        dup_err_o
);

    eoc_state_e          state_q, state_d;
    logic [N_TILES-1:0]  mask_q, mask_d;
    logic [N_TILES-1:0]  done_q, done_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [ID_W-1:0]     fid_q, fid_d;
    logic                dup_q, dup_d;

    logic                run;
    logic                start_acc;
    logic [N_TILES-1:0]  accept;
    logic [N_TILES-1:0]  fresh;
    logic [N_TILES-1:0]  stale;
    logic                all_done;
    logic                timeout_hit;
    logic                pick_valid;
    logic [ID_W-1:0]     pick_id;
    logic [CODE_W-1:0]   pick_code;

    assign run       = (state_q == EOC_RUN);
    assign start_acc = (state_q == EOC_IDLE) && start_i;
    assign accept    = rpt_valid_i & {N_TILES{run}};
    assign fresh     = accept & mask_q & ~done_q;
    assign stale     = accept & ~fresh;
    assign all_done  = &(done_q | ~mask_q);

    // Lowest-index fresh report with a nonzero code; scanning downwards lets the lowest index overwrite.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        pick_code  = '0;
        for (int t = N_TILES - 1; t >= 0; t--) begin
            if (fresh[t] && (rpt_code_i[t*CODE_W +: CODE_W] != '0)) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'(t);
                pick_code  = rpt_code_i[t*CODE_W +: CODE_W];
            end
        end
    end

`ifdef MAGIA_EOC_WATCHDOG_EN
    logic [TMO_W-1:0] tmo_q;
    logic             expire;
    logic             still_open;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else if (start_acc) begin
            tmo_q <= timeout_i;
        end
    end

    magia_eoc_watchdog #(
        .TMO_W (TMO_W)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (start_acc),
        .enable_i (run),
        .limit_i  (tmo_q),
        .expire_o (expire)
    );

    // Reports landing in the expiry cycle count, so a last report beats the watchdog.
    assign still_open  = ~&(done_q | fresh | ~mask_q);
    assign timeout_hit = expire && still_open;
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_i;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EOC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EOC_IDLE: begin
                if (start_i) state_d = EOC_RUN;
            end
            EOC_RUN: begin
                if (all_done)         state_d = EOC_DONE;
                else if (timeout_hit) state_d = EOC_TIMEOUT;
            end
            EOC_DONE, EOC_TIMEOUT: begin
                if (clear_i) state_d = EOC_IDLE;
            end
            default: state_d = EOC_IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        eoc_o  = 1'b0;
        case (state_q)
            EOC_RUN:               busy_o = 1'b1;
            EOC_DONE, EOC_TIMEOUT: eoc_o  = 1'b1;
            default: ;
        endcase
    end

    assign rpt_ready_o = {N_TILES{busy_o}};

    always_comb begin
        mask_d = mask_q;
        done_d = done_q;
        code_d = code_q;
        fid_d  = fid_q;
        dup_d  = dup_q;
        if (start_acc) begin
            mask_d = tile_mask_i;
            done_d = '0;
            code_d = '0;
            fid_d  = '0;
            dup_d  = 1'b0;
        end else if (run) begin
            done_d = done_q | accept;
            if (|stale) dup_d = 1'b1;
            // A nonzero code is only ever latched once per run, so a zero register means "none yet".
            if (pick_valid && (code_q == '0)) begin
                code_d = pick_code;
                fid_d  = pick_id;
            end
            if (timeout_hit) begin
                code_d = TMO_CODE;
                fid_d  = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q <= '0;
            done_q <= '0;
            code_q <= '0;
            fid_q  <= '0;
            dup_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            done_q <= done_d;
            code_q <= code_d;
            fid_q  <= fid_d;
            dup_q  <= dup_d;
        end
    end

    assign exit_code_o = code_q;
    assign fail_id_o   = fid_q;
    assign done_map_o  = done_q;
    assign dup_err_o   = dup_q;

endmodule

// File: tb/tb_magia_eoc_collector.sv
// Self-checking bench for magia_eoc_collector (4 tiles): directed table, multi-cycle corner
// sequences and a randomized run against a behavioural model. Honours MAGIA_EOC_WATCHDOG_EN.
module tb_magia_eoc_collector;
    import magia_eoc_pkg::*;

    localparam int N  = 4;
    localparam int CW = 32;
    localparam int TW = 32;
    localparam int IW = 2;
`ifdef MAGIA_EOC_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            start_i, clear_i;
    logic [N-1:0]    tile_mask_i;
    logic [TW-1:0]   timeout_i;
    logic [N-1:0]    rpt_valid_i;
    logic [N*CW-1:0] rpt_code_i;
    logic [N-1:0]    rpt_ready_o;
    logic            busy_o, eoc_o, dup_err_o;
    logic [CW-1:0]   exit_code_o;
    logic [IW-1:0]   fail_id_o;
    logic [N-1:0]    done_map_o;

    magia_eoc_collector #(.N_TILES(N), .CODE_W(CW), .TMO_W(TW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .clear_i     (clear_i),
        .tile_mask_i (tile_mask_i),
        .timeout_i   (timeout_i),
        .rpt_valid_i (rpt_valid_i),
        .rpt_code_i  (rpt_code_i),
        .rpt_ready_o (rpt_ready_o),
        .busy_o      (busy_o),
        .eoc_o       (eoc_o),
        .exit_code_o (exit_code_o),
        .fail_id_o   (fail_id_o),
        .done_map_o  (done_map_o),
        .dup_err_o   (dup_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: one collection round as sets of tiles and a "first nonzero code" rule.
    bit            m_busy, m_eoc, m_dup;
    bit [N-1:0]    m_mask, m_done;
    logic [CW-1:0] m_code;
    int            m_fid;
    int unsigned   m_tmo, m_cnt;

    task automatic model_reset();
        m_busy = 0; m_eoc = 0; m_dup = 0;
        m_mask = '0; m_done = '0; m_code = '0; m_fid = 0;
        m_tmo = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit         complete;
        bit         open_after;
        bit [N-1:0] now;
        logic [CW-1:0] c;
        if (!m_busy && !m_eoc) begin
            if (start_i) begin
                m_busy = 1; m_done = '0; m_code = '0; m_fid = 0; m_dup = 0;
                m_mask = tile_mask_i; m_tmo = timeout_i; m_cnt = 0;
            end
        end else if (m_eoc) begin
            if (clear_i) m_eoc = 0;
        end else begin
            complete = 1;
            for (int t = 0; t < N; t++) if (m_mask[t] && !m_done[t]) complete = 0;
            now = m_done;
            for (int t = 0; t < N; t++) begin
                if (rpt_valid_i[t]) begin
                    c = rpt_code_i[t*CW +: CW];
                    if (m_done[t] || !m_mask[t]) m_dup = 1;
                    else if (m_code == 0 && c != 0) begin
                        m_code = c;
                        m_fid  = t;
                    end
                    now[t] = 1;
                end
            end
            open_after = 0;
            for (int t = 0; t < N; t++) if (m_mask[t] && !now[t]) open_after = 1;
            m_done = now;
            if (complete) begin
                m_busy = 0; m_eoc = 1;
            end else if (WD_ON && m_tmo != 0 && m_cnt == m_tmo - 1 && open_after) begin
                m_busy = 0; m_eoc = 1; m_code = 32'hDEAD_0001; m_fid = 0;
            end
            m_cnt++;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        start_i = 0; clear_i = 0; tile_mask_i = '0; timeout_i = '0;
        rpt_valid_i = '0; rpt_code_i = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_ni = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1;
    endtask

    task automatic check_all(input string tag, input bit b, input bit e, input logic [CW-1:0] c,
                             input logic [IW-1:0] f, input logic [N-1:0] d, input bit du);
        check({tag, "/busy"},  busy_o,      b);
        check({tag, "/eoc"},   eoc_o,       e);
        check({tag, "/code"},  exit_code_o, c);
        check({tag, "/fid"},   fail_id_o,   f);
        check({tag, "/done"},  done_map_o,  d);
        check({tag, "/dup"},   dup_err_o,   du);
        check({tag, "/ready"}, rpt_ready_o, {N{b}});
    endtask

    typedef struct {
        string         name;
        bit            start;
        bit            clear;
        bit [N-1:0]    mask;
        bit [N-1:0]    valid;
        bit [N*CW-1:0] codes;
        bit            busy;
        bit            eoc;
        bit [CW-1:0]   code;
        bit [IW-1:0]   fid;
        bit [N-1:0]    done;
        bit            dup;
    } vec_t;

    function automatic vec_t mk(string n, bit s, bit c, bit [N-1:0] m, bit [N-1:0] v, bit [N*CW-1:0] cd,
                                bit b, bit e, bit [CW-1:0] ec, bit [IW-1:0] f, bit [N-1:0] d, bit du);
        vec_t r;
        r.name = n; r.start = s; r.clear = c; r.mask = m; r.valid = v; r.codes = cd;
        r.busy = b; r.eoc = e; r.code = ec; r.fid = f; r.done = d; r.dup = du;
        return r;
    endfunction

    vec_t vecs[$];
    localparam bit [N*CW-1:0] Z = '0;

    initial begin
        logic [CW-1:0] exp_code;

        // Codes are packed {tile3, tile2, tile1, tile0}.
        vecs.push_back(mk("agg_start",  1, 0, 4'hF, 4'h0, Z,                         1, 0, 32'h0, 2'd0, 4'h0, 0));
        vecs.push_back(mk("agg_tie",    0, 0, 4'hF, 4'hA, {32'h9, 32'h0, 32'h5, 32'h0}, 1, 0, 32'h5, 2'd1, 4'hA, 0));
        vecs.push_back(mk("agg_rest",   0, 0, 4'hF, 4'h5, Z,                         1, 0, 32'h5, 2'd1, 4'hF, 0));
        vecs.push_back(mk("agg_done",   0, 0, 4'h0, 4'h0, Z,                         0, 1, 32'h5, 2'd1, 4'hF, 0));
        vecs.push_back(mk("agg_clear",  0, 1, 4'h0, 4'h0, Z,                         0, 0, 32'h5, 2'd1, 4'hF, 0));
        vecs.push_back(mk("dup_start",  1, 0, 4'h5, 4'h0, Z,                         1, 0, 32'h0, 2'd0, 4'h0, 0));
        vecs.push_back(mk("dup_t0a",    0, 0, 4'h5, 4'h1, Z,                         1, 0, 32'h0, 2'd0, 4'h1, 0));
        vecs.push_back(mk("dup_t0b",    0, 0, 4'h5, 4'h1, {32'h0, 32'h0, 32'h0, 32'h7}, 1, 0, 32'h0, 2'd0, 4'h1, 1));
        vecs.push_back(mk("dup_t2",     0, 0, 4'h5, 4'h4, {32'h0, 32'h3, 32'h0, 32'h0}, 1, 0, 32'h3, 2'd2, 4'h5, 1));
        vecs.push_back(mk("dup_done",   0, 0, 4'h5, 4'h0, Z,                         0, 1, 32'h3, 2'd2, 4'h5, 1));
        vecs.push_back(mk("dup_ign",    1, 0, 4'hF, 4'hF, {4{32'hAA}},               0, 1, 32'h3, 2'd2, 4'h5, 1));
        vecs.push_back(mk("dup_clear",  0, 1, 4'h0, 4'h0, Z,                         0, 0, 32'h3, 2'd2, 4'h5, 1));
        vecs.push_back(mk("empty_start",1, 0, 4'h0, 4'h0, Z,                         1, 0, 32'h0, 2'd0, 4'h0, 0));
        vecs.push_back(mk("empty_done", 0, 0, 4'h0, 4'h0, Z,                         0, 1, 32'h0, 2'd0, 4'h0, 0));
        vecs.push_back(mk("empty_hold", 1, 0, 4'h0, 4'h0, Z,                         0, 1, 32'h0, 2'd0, 4'h0, 0));
        vecs.push_back(mk("empty_clear",0, 1, 4'h0, 4'h0, Z,                         0, 0, 32'h0, 2'd0, 4'h0, 0));

        // Reset state, observed while reset is still asserted.
        idle_inputs();
        rst_ni = 0;
        model_reset();
        #12;
        check_all("reset", 0, 0, '0, '0, '0, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1;

        foreach (vecs[i]) begin
            start_i = vecs[i].start; clear_i = vecs[i].clear; tile_mask_i = vecs[i].mask;
            timeout_i = '0; rpt_valid_i = vecs[i].valid; rpt_code_i = vecs[i].codes;
            cycle();
            check_all(vecs[i].name, vecs[i].busy, vecs[i].eoc, vecs[i].code, vecs[i].fid,
                      vecs[i].done, vecs[i].dup);
        end
        idle_inputs();

        // Latency: reports at edges 2,5,7,9 after the start edge -> eoc after edge 10.
        start_i = 1; tile_mask_i = 4'hF;
        cycle();
        idle_inputs();
        for (int k = 1; k <= 12; k++) begin
            rpt_valid_i = (k == 2) ? 4'b0001 : (k == 5) ? 4'b0010 :
                          (k == 7) ? 4'b0100 : (k == 9) ? 4'b1000 : 4'b0000;
            cycle();
            check($sformatf("lat_eoc@%0d", k),  eoc_o,  k >= 10);
            check($sformatf("lat_busy@%0d", k), busy_o, k < 10);
        end
        rpt_valid_i = '0;
        check("lat_done", done_map_o, 4'hF);
        check("lat_code", exit_code_o, 32'h0);
        clear_i = 1;
        cycle();
        clear_i = 0;

        // Watchdog: tile 3 silent, limit 100 -> TIMEOUT after the 100th RUN cycle.
        start_i = 1; tile_mask_i = 4'hF; timeout_i = 100;
        cycle();
        idle_inputs();
        for (int k = 1; k <= 105; k++) begin
            rpt_valid_i = (k == 1) ? 4'b0111 : 4'b0000;
            cycle();
            check($sformatf("wd_eoc@%0d", k),  eoc_o,  WD_ON && k >= 100);
            check($sformatf("wd_busy@%0d", k), busy_o, !(WD_ON && k >= 100));
        end
        exp_code = WD_ON ? 32'hDEAD_0001 : 32'h0;
        check("wd_code", exit_code_o, exp_code);
        check("wd_fid",  fail_id_o,   2'd0);
        check("wd_done", done_map_o,  4'h7);
        apply_reset();

        // Last report in the expiry cycle: DONE wins and keeps tile 3's code.
        start_i = 1; tile_mask_i = 4'hF; timeout_i = 20;
        cycle();
        idle_inputs();
        for (int k = 1; k <= 22; k++) begin
            rpt_valid_i = (k == 1) ? 4'b0111 : (k == 20) ? 4'b1000 : 4'b0000;
            rpt_code_i  = (k == 20) ? {32'h44, 32'h0, 32'h0, 32'h0} : Z;
            cycle();
            check($sformatf("race_eoc@%0d", k), eoc_o, k >= 21);
        end
        idle_inputs();
        check("race_code", exit_code_o, 32'h44);
        check("race_fid",  fail_id_o,   2'd3);
        clear_i = 1;
        cycle();
        clear_i = 0;

        // Asynchronous reset mid-RUN with two tiles done.
        start_i = 1; tile_mask_i = 4'hF;
        cycle();
        idle_inputs();
        rpt_valid_i = 4'b0011; rpt_code_i = {32'h0, 32'h0, 32'h0, 32'h6};
        cycle();
        idle_inputs();
        check("rst_pre_done", done_map_o, 4'h3);
        check("rst_pre_code", exit_code_o, 32'h6);
        #1;
        rst_ni = 0;
        model_reset();
        #1;
        check_all("rst_async", 0, 0, '0, '0, '0, 0);
        @(posedge clk_i);
        #1;
        check_all("rst_held", 0, 0, '0, '0, '0, 0);
        rst_ni = 1;
        start_i = 1; tile_mask_i = 4'hF;
        cycle();
        idle_inputs();
        check_all("rst_restart", 1, 0, '0, '0, '0, 0);

        // Randomized traffic against the model.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            start_i     = ($urandom_range(0, 3) == 0);
            clear_i     = ($urandom_range(0, 3) == 0);
            tile_mask_i = N'($urandom);
            timeout_i   = $urandom_range(0, 25);
            for (int t = 0; t < N; t++) begin
                rpt_valid_i[t] = ($urandom_range(0, 5) == 0);
                rpt_code_i[t*CW +: CW] = ($urandom_range(0, 2) == 0) ? CW'($urandom_range(1, 15)) : '0;
            end
            cycle();
            check_all($sformatf("rnd@%0d", i), m_busy, m_eoc, m_code, IW'(m_fid), m_done, m_dup);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
